// File: rtl/lcd_msg_buffer.sv
// lcd_msg_buffer: writable character buffer that drives the LCD driver's
// flattened text bus (char 0 in the most-significant byte).
// Supports byte-addressed writes with ack/err pulses, a multi-cycle
// clear-to-spaces sequence and a dirty flag for the display path.
// Optional feature macro: LCD_SCROLL_EN (timed horizontal scroll).
module lcd_msg_buffer #(
  parameter int NUM_CHARS  = 28,
  parameter int ADDR_W     = 5,
  parameter int SCROLL_DIV = 12500000
) (
  input  logic                   clk_i,
  input  logic                   clrn_i,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic [7:0]             wr_data_i,
  output logic                   wr_ack_o,
  output logic                   wr_err_o,
  input  logic                   clr_i,
  output logic                   busy_o,
  output logic                   dirty_o,
  input  logic                   dirty_clr_i,
  input  logic                   scroll_en_i,
  output logic [NUM_CHARS*8-1:0] disp_data_o
);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  state_e state_q, state_d;

  logic [7:0]        charBuf_q [NUM_CHARS];
  logic [7:0]        charBuf_d [NUM_CHARS];
  logic [ADDR_W-1:0] clrPtr_q, clrPtr_d;
  logic              wrAck_q, wrErr_q;
  logic              dirty_q, dirty_d;

  logic              busy;
  logic              clrLast;
  logic              clrDone;
  logic              addrOk;
  logic              wrAccept;
  logic              wrReject;

  // State register; reset abandons any clear in progress.
  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a clear starts from idle and ends after the last index.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_i)   state_d = ST_CLEAR;
      ST_CLEAR: if (clrLast) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Decoded controls: busy, clear completion and write acceptance.
  always_comb begin
    busy     = (state_q == ST_CLEAR);
    clrLast  = busy && (clrPtr_q == ADDR_W'(NUM_CHARS - 1));
    clrDone  = clrLast;
    addrOk   = ({1'b0, wr_addr_i} < (ADDR_W + 1)'(NUM_CHARS));
    wrAccept = wr_en_i && !busy && !clr_i && addrOk;
    wrReject = wr_en_i && !wrAccept;
  end

  assign busy_o   = busy;
  assign wr_ack_o = wrAck_q;
  assign wr_err_o = wrErr_q;
  assign dirty_o  = dirty_q;

  // Clear pointer walks 0..NUM_CHARS-1 while busy and parks at 0 otherwise.
  always_comb begin
    clrPtr_d = '0;
    if (busy && !clrLast) begin
      clrPtr_d = clrPtr_q + 1'b1;
    end
  end

  // Buffer update: the clear sweep and accepted writes never overlap.
  always_comb begin
    charBuf_d = charBuf_q;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (busy && (clrPtr_q == ADDR_W'(i))) begin
        charBuf_d[i] = 8'h20;
      end else if (wrAccept && (wr_addr_i == ADDR_W'(i))) begin
        charBuf_d[i] = wr_data_i;
      end
    end
  end

  // Dirty flag: a set event beats a simultaneous dirty_clr.
  always_comb begin
    dirty_d = dirty_q;
    if (wrAccept || clrDone) begin
      dirty_d = 1'b1;
    end else if (dirty_clr_i) begin
      dirty_d = 1'b0;
    end
  end

  // Datapath registers: buffer, clear pointer, pulses and dirty flag.
  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      charBuf_q <= '{default: 8'h20};
      clrPtr_q  <= '0;
      wrAck_q   <= 1'b0;
      wrErr_q   <= 1'b0;
      dirty_q   <= 1'b0;
    end else begin
      charBuf_q <= charBuf_d;
      clrPtr_q  <= clrPtr_d;
      wrAck_q   <= wrAccept;
      wrErr_q   <= wrReject;
      dirty_q   <= dirty_d;
    end
  end

`ifdef LCD_SCROLL_EN
  localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [ADDR_W-1:0] offset_q, offset_d;

  // Scroll timing: clear completion rewinds, otherwise advance while enabled.
  always_comb begin
    div_d    = div_q;
    offset_d = offset_q;
    if (clrDone) begin
      div_d    = '0;
      offset_d = '0;
    end else if (scroll_en_i) begin
      if (div_q == DIV_W'(SCROLL_DIV - 1)) begin
        div_d    = '0;
        offset_d = (offset_q == ADDR_W'(NUM_CHARS - 1)) ? '0 : offset_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Scroll divider and offset registers.
  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      div_q    <= '0;
      offset_q <= '0;
    end else begin
      div_q    <= div_d;
      offset_q <= offset_d;
    end
  end

  // Display slot j shows buffer char (j + offset) mod NUM_CHARS.
  always_comb begin
    int sel;
    disp_data_o = '0;
    for (int j = 0; j < NUM_CHARS; j++) begin
      sel = j + int'(offset_q);
      if (sel >= NUM_CHARS) begin
        sel = sel - NUM_CHARS;
      end
      for (int i = 0; i < NUM_CHARS; i++) begin
        if (sel == i) begin
          disp_data_o[8*(NUM_CHARS-j)-1 -: 8] = charBuf_q[i];
        end
      end
    end
  end
`else
  logic unused_scroll;
  assign unused_scroll = scroll_en_i ^ (SCROLL_DIV == 0);

  // Without scrolling the buffer maps straight onto the display bus.
  always_comb begin
    disp_data_o = '0;
    for (int j = 0; j < NUM_CHARS; j++) begin
      disp_data_o[8*(NUM_CHARS-j)-1 -: 8] = charBuf_q[j];
    end
  end
`endif

endmodule

// File: tb/tb_lcd_msg_buffer.sv
// tb_lcd_msg_buffer: directed vector table, scroll sequence, randomized
// traffic against a behavioural model, and an asynchronous reset mid-clear.
module tb_lcd_msg_buffer;

  localparam int NC = 4;
  localparam int AW = 3;
  localparam int SD = 3;

  logic          clk = 1'b0;
  logic          clrn;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [7:0]    wrData;
  logic          clr;
  logic          dirtyClr;
  logic          scrollEn;
  logic          wrAck;
  logic          wrErr;
  logic          busy;
  logic          dirty;
  logic [NC*8-1:0] dispData;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  bit [7:0] mBuf [NC];
  int       mClearLeft;
  bit       mAck, mErr, mDirty;
  int       mScroll;

  typedef struct {
    bit          wrEn;
    bit [AW-1:0] addr;
    bit [7:0]    data;
    bit          clr;
    bit          dclr;
    logic [31:0] expDisp;
    bit          expAck, expErr, expBusy, expDirty;
  } vec_t;

  vec_t dirVec [$];

  lcd_msg_buffer #(
    .NUM_CHARS (NC),
    .ADDR_W    (AW),
    .SCROLL_DIV(SD)
  ) dut (
    .clk_i      (clk),
    .clrn_i     (clrn),
    .wr_en_i    (wrEn),
    .wr_addr_i  (wrAddr),
    .wr_data_i  (wrData),
    .wr_ack_o   (wrAck),
    .wr_err_o   (wrErr),
    .clr_i      (clr),
    .busy_o     (busy),
    .dirty_o    (dirty),
    .dirty_clr_i(dirtyClr),
    .scroll_en_i(scrollEn),
    .disp_data_o(dispData)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic vec_t mk(bit w, bit [AW-1:0] a, bit [7:0] d, bit c, bit dc,
                              logic [31:0] e, bit ea, bit ee, bit eb, bit ed);
    vec_t v;
    v.wrEn = w; v.addr = a; v.data = d; v.clr = c; v.dclr = dc;
    v.expDisp = e; v.expAck = ea; v.expErr = ee; v.expBusy = eb; v.expDirty = ed;
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NC; i++) mBuf[i] = 8'h20;
    mClearLeft = 0;
    mAck = 0; mErr = 0; mDirty = 0;
    mScroll = 0;
  endtask

  // One clock edge of the reference model, written from the block's rules.
  task automatic modelStep(bit w, bit [AW-1:0] a, bit [7:0] d, bit c, bit dc, bit s);
    bit accept, setDirty, wasBusy;
    wasBusy  = (mClearLeft > 0);
    accept   = w && !wasBusy && !c && (int'(a) < NC);
    mAck     = accept;
    mErr     = w && !accept;
    setDirty = accept;
    if (wasBusy) begin
      mBuf[NC - mClearLeft] = 8'h20;
      mClearLeft--;
      if (mClearLeft == 0) begin
        setDirty = 1;
        mScroll  = 0;
      end else if (s) begin
        mScroll++;
      end
    end else begin
      if (c) mClearLeft = NC;
      if (s) mScroll++;
    end
    if (accept) mBuf[a] = d;
    if (setDirty) mDirty = 1;
    else if (dc) mDirty = 0;
  endtask

  function automatic logic [31:0] modelDisp();
    logic [31:0] r;
    int off;
    off = 0;
`ifdef LCD_SCROLL_EN
    off = (mScroll / SD) % NC;
`endif
    for (int j = 0; j < NC; j++) r[8*(NC-j)-1 -: 8] = mBuf[(j + off) % NC];
    return r;
  endfunction

  // Drive one cycle of inputs, advance the model with the edge, sample after.
  task automatic applyStimulus(bit w, bit [AW-1:0] a, bit [7:0] d, bit c, bit dc, bit s);
    wrEn = w; wrAddr = a; wrData = d; clr = c; dirtyClr = dc; scrollEn = s;
    @(posedge clk);
    modelStep(w, a, d, c, dc, s);
    #1;
  endtask

  task automatic checkField(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(string tag, logic [31:0] eDisp, bit eAck, bit eErr,
                             bit eBusy, bit eDirty);
    checkField({tag, ".disp"},  dispData,  eDisp);
    checkField({tag, ".ack"},   32'(wrAck), 32'(eAck));
    checkField({tag, ".err"},   32'(wrErr), 32'(eErr));
    checkField({tag, ".busy"},  32'(busy),  32'(eBusy));
    checkField({tag, ".dirty"}, 32'(dirty), 32'(eDirty));
  endtask

  task automatic checkModel(string tag);
    checkOutput(tag, modelDisp(), mAck, mErr, mClearLeft > 0, mDirty);
  endtask

  initial begin
    wrEn = 0; wrAddr = '0; wrData = '0; clr = 0; dirtyClr = 0; scrollEn = 0;
    clrn = 0;
    modelReset();

    dirVec.push_back(mk(1, 0, 8'h48, 0, 0, 32'h48202020, 1, 0, 0, 1));
    dirVec.push_back(mk(1, 3, 8'h69, 0, 0, 32'h48202069, 1, 0, 0, 1));
    dirVec.push_back(mk(0, 0, 8'h00, 0, 0, 32'h48202069, 0, 0, 0, 1));
    dirVec.push_back(mk(1, 5, 8'h77, 0, 0, 32'h48202069, 0, 1, 0, 1));
    dirVec.push_back(mk(0, 0, 8'h00, 0, 0, 32'h48202069, 0, 0, 0, 1));
    dirVec.push_back(mk(0, 0, 8'h00, 0, 1, 32'h48202069, 0, 0, 0, 0));
    dirVec.push_back(mk(1, 0, 8'h41, 0, 0, 32'h41202069, 1, 0, 0, 1));
    dirVec.push_back(mk(1, 1, 8'h42, 0, 0, 32'h41422069, 1, 0, 0, 1));
    dirVec.push_back(mk(1, 2, 8'h43, 0, 0, 32'h41424369, 1, 0, 0, 1));
    dirVec.push_back(mk(1, 3, 8'h44, 0, 0, 32'h41424344, 1, 0, 0, 1));
    dirVec.push_back(mk(1, 1, 8'h5A, 1, 1, 32'h41424344, 0, 1, 1, 0));
    dirVec.push_back(mk(0, 0, 8'h00, 1, 0, 32'h20424344, 0, 0, 1, 0));
    dirVec.push_back(mk(0, 0, 8'h00, 0, 0, 32'h20204344, 0, 0, 1, 0));
    dirVec.push_back(mk(1, 2, 8'h55, 0, 0, 32'h20202044, 0, 1, 1, 0));
    dirVec.push_back(mk(0, 0, 8'h00, 0, 0, 32'h20202020, 0, 0, 0, 1));
    dirVec.push_back(mk(0, 0, 8'h00, 0, 0, 32'h20202020, 0, 0, 0, 1));
    dirVec.push_back(mk(0, 0, 8'h00, 0, 1, 32'h20202020, 0, 0, 0, 0));
    dirVec.push_back(mk(1, 0, 8'h31, 0, 1, 32'h31202020, 1, 0, 0, 1));
    dirVec.push_back(mk(0, 0, 8'h00, 0, 1, 32'h31202020, 0, 0, 0, 0));

    // Reset state, both during reset and after the first idle edge.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("inReset", 32'h20202020, 0, 0, 0, 0);
    @(negedge clk);
    clrn = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("reset", 32'h20202020, 0, 0, 0, 0);

    // Directed table.
    for (int i = 0; i < dirVec.size(); i++) begin
      applyStimulus(dirVec[i].wrEn, dirVec[i].addr, dirVec[i].data,
                    dirVec[i].clr, dirVec[i].dclr, 1'b0);
      checkOutput($sformatf("dir%0d", i), dirVec[i].expDisp, dirVec[i].expAck,
                  dirVec[i].expErr, dirVec[i].expBusy, dirVec[i].expDirty);
    end

`ifdef LCD_SCROLL_EN
    // Scroll sequence on "ABCD": rotate every SD cycles, wrap, then freeze.
    for (int i = 0; i < NC; i++) begin
      applyStimulus(1, AW'(i), 8'h41 + 8'(i), 0, 0, 0);
      checkModel($sformatf("abcd%0d", i));
    end
    checkField("abcd.disp", dispData, 32'h41424344);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkModel($sformatf("scroll%0d", k));
      if (k == 3)  checkField("scroll.step1", dispData, 32'h42434441);
      if (k == 12) checkField("scroll.wrap",  dispData, 32'h41424344);
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkField($sformatf("scroll.hold%0d", k), dispData, 32'h42434441);
    end
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom % 2), AW'($urandom % 8), 8'($urandom),
                    ($urandom % 16) == 0, ($urandom % 4) == 0, ($urandom % 4) != 0);
      checkModel($sformatf("rnd%0d", n));
    end

    // Asynchronous reset in the middle of a clear sequence.
    for (int n = 0; n < 2 * NC && mClearLeft > 0; n++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    checkField("preClear.busy", 32'(busy), 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 8'h7E, 0, 0, 0);
    checkModel("midClear");
    #2;
    clrn = 0;
    modelReset();
    #1;
    checkOutput("asyncReset", 32'h20202020, 0, 0, 0, 0);
    @(negedge clk);
    clrn = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkModel("afterReset");
    applyStimulus(1, 2, 8'h3F, 0, 0, 0);
    checkModel("postResetWrite");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
